// File: rtl/evm_pkg.sv
// rtl/evm_pkg.sv - shared states and widths for the EVM ballot controller
package evm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    COMMIT = 3'd2,
    BEEP   = 3'd3,
    CLOSED = 3'd4
  } state_t;

  localparam int VOTE_CNT_W = 16;

endpackage

// File: rtl/ballot_controller_if.sv
// rtl/ballot_controller_if.sv - vote commit handshake between controller and tally
interface ballot_controller_if #(
  parameter int N_CAND = 4
) ();

  localparam int IDX_W = $clog2(N_CAND);

  logic             vote_valid;
  logic [IDX_W-1:0] vote_idx;
  logic             vote_ready;

  modport master (output vote_valid, output vote_idx, input vote_ready);
  modport slave  (input vote_valid, input vote_idx, output vote_ready);

endinterface

// File: rtl/onehot_encoder.sv
// rtl/onehot_encoder.sv - flags exactly-one-bit-set and returns that bit's index
module onehot_encoder #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] bits,
  output logic         one,
  output logic [W-1:0] idx
);

  // Clearing the lowest set bit leaves zero only when a single bit was set.
  assign one = (bits != '0) && ((bits & (bits - N'(1))) == '0);

  // Index of the set bit; only meaningful when one is high.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bits[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/ballot_controller.sv
// rtl/ballot_controller.sv - one-voter-one-vote sequencer for the EVM
module ballot_controller
  import evm_pkg::*;
#(
  parameter int N_CAND         = 4,
  parameter int BEEP_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clock,
  input  logic                  Reset,
  input  logic                  ballot_pulse,
  input  logic                  close_poll,
  input  logic [N_CAND-1:0]     cand_pulse,
  ballot_controller_if.master   vote,
  output logic                  ready_led,
  output logic                  beep,
  output logic                  timeout_flag,
  output logic                  poll_closed,
  output logic [VOTE_CNT_W-1:0] votes_cast
);

  localparam int IW = $clog2(N_CAND);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_CYCLES - 1);

  state_t                  state, state_next;
  logic [TW-1:0]           timer;
  logic [BW-1:0]           beep_cnt;
  logic [IW-1:0]           idx_q;
  logic                    tflag_q;
  logic [VOTE_CNT_W-1:0]   vote_cnt;
  logic                    press_one;
  logic [IW-1:0]           press_idx;
  logic                    expire;
  logic                    accept;

  onehot_encoder #(.N(N_CAND), .W(IW)) u_enc (
    .bits (cand_pulse),
    .one  (press_one),
    .idx  (press_idx)
  );

  // A valid press on the terminal timer cycle wins, so expiry excludes it.
  assign expire = (state == ARMED) && !press_one && (timer == TIMER_LAST);
  assign accept = (state == COMMIT) && vote.vote_ready;

  // Next-state decode; close wins over ballot in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (close_poll)        state_next = CLOSED;
        else if (ballot_pulse) state_next = ARMED;
      end
      ARMED: begin
        if (press_one)   state_next = COMMIT;
        else if (expire) state_next = IDLE;
      end
      COMMIT: if (vote.vote_ready) state_next = BEEP;
      BEEP:   if (beep_cnt == BEEP_LAST) state_next = IDLE;
      CLOSED: state_next = CLOSED;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Ballot timer: held at zero outside ARMED so every arming starts fresh.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset)                   timer <= '0;
    else if (state != ARMED)      timer <= '0;
    else if (timer != TIMER_LAST) timer <= timer + TW'(1);
  end

  // Beep counter: zero on entry to BEEP, counts the held cycles.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset)                     beep_cnt <= '0;
    else if (state != BEEP)         beep_cnt <= '0;
    else if (beep_cnt != BEEP_LAST) beep_cnt <= beep_cnt + BW'(1);
  end

  // Latch the pressed candidate; held stable through COMMIT.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset)                          idx_q <= '0;
    else if (state == ARMED && press_one) idx_q <= press_idx;
  end

  // One-cycle expiry pulse.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) tflag_q <= 1'b0;
    else        tflag_q <= expire;
  end

  // Saturating committed-vote counter, stepped only on an accepted commit.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset)                        vote_cnt <= '0;
    else if (accept && vote_cnt != '1) vote_cnt <= vote_cnt + VOTE_CNT_W'(1);
  end

  assign ready_led       = (state == ARMED);
  assign vote.vote_valid = (state == COMMIT);
  assign vote.vote_idx   = idx_q;
  assign beep            = (state == BEEP);
  assign poll_closed     = (state == CLOSED);
  assign timeout_flag    = tflag_q;
  assign votes_cast      = vote_cnt;

endmodule

// File: tb/tb_ballot_controller.sv
// tb/tb_ballot_controller.sv - directed checks of ballot_controller
module tb_ballot_controller;

  logic        clock = 1'b0;
  logic        Reset;
  logic        ballot_pulse;
  logic        close_poll;
  logic [3:0]  cand_pulse;
  logic        ready_led, beep, timeout_flag, poll_closed;
  logic [15:0] votes_cast;

  int checks = 0;
  int errors = 0;

  ballot_controller_if #(.N_CAND(4)) vote ();

  ballot_controller #(
    .N_CAND(4), .BEEP_CYCLES(8), .TIMEOUT_CYCLES(20)
  ) dut (
    .clock        (clock),
    .Reset        (Reset),
    .ballot_pulse (ballot_pulse),
    .close_poll   (close_poll),
    .cand_pulse   (cand_pulse),
    .vote         (vote),
    .ready_led    (ready_led),
    .beep         (beep),
    .timeout_flag (timeout_flag),
    .poll_closed  (poll_closed),
    .votes_cast   (votes_cast)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ballot;
    logic        close;
    logic [3:0]  cand;
    logic        ready;
    logic [22:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [22:0] o(input logic v, input logic [1:0] idx, input logic rdy,
                                    input logic bp, input logic tf, input logic cl,
                                    input logic [15:0] n);
    return {v, idx, rdy, bp, tf, cl, n};
  endfunction

  task automatic add(input logic b, input logic c, input logic [3:0] cd, input logic r,
                     input logic [22:0] e);
    vec_t t;
    t.ballot = b; t.close = c; t.cand = cd; t.ready = r; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic b, input logic c, input logic [3:0] cd, input logic r);
    ballot_pulse = b; close_poll = c; cand_pulse = cd; vote.vote_ready = r;
    @(posedge clock);
    #1;
    ballot_pulse = 1'b0; close_poll = 1'b0; cand_pulse = 4'b0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'b0, 1'b1);
  endtask

  logic [22:0] obs;
  assign obs = {vote.vote_valid, vote.vote_idx, ready_led, beep, timeout_flag, poll_closed, votes_cast};

  initial begin
    int first;
    int pulses;

    // Scenario 1: vote for candidate 2; ballot during BEEP is ignored.
    add(1, 0, 4'b0000, 1, o(0, 0, 1, 0, 0, 0, 16'd0));
    add(0, 0, 4'b0000, 1, o(0, 0, 1, 0, 0, 0, 16'd0));
    add(0, 0, 4'b0000, 1, o(0, 0, 1, 0, 0, 0, 16'd0));
    add(0, 0, 4'b0100, 1, o(1, 2, 0, 0, 0, 0, 16'd0));
    add(0, 0, 4'b0000, 1, o(0, 2, 0, 1, 0, 0, 16'd1));
    for (int i = 0; i < 7; i++) add(i == 3, 0, 4'b0000, 1, o(0, 2, 0, 1, 0, 0, 16'd1));
    add(0, 0, 4'b0000, 1, o(0, 2, 0, 0, 0, 0, 16'd1));
    add(0, 0, 4'b0001, 1, o(0, 2, 0, 0, 0, 0, 16'd1));
    // Scenario 2: ambiguous presses ignored, then candidate 0.
    add(1, 0, 4'b0000, 1, o(0, 2, 1, 0, 0, 0, 16'd1));
    add(0, 0, 4'b0110, 1, o(0, 2, 1, 0, 0, 0, 16'd1));
    add(1, 0, 4'b1111, 1, o(0, 2, 1, 0, 0, 0, 16'd1));
    add(0, 0, 4'b0001, 1, o(1, 0, 0, 0, 0, 0, 16'd1));
    add(0, 0, 4'b0000, 1, o(0, 0, 0, 1, 0, 0, 16'd2));
    for (int i = 0; i < 7; i++) add(0, 0, 4'b0000, 1, o(0, 0, 0, 1, 0, 0, 16'd2));
    add(0, 0, 4'b0000, 1, o(0, 0, 0, 0, 0, 0, 16'd2));
    // Highest candidate; close_poll during COMMIT is ignored.
    add(1, 0, 4'b0000, 1, o(0, 0, 1, 0, 0, 0, 16'd2));
    add(0, 0, 4'b1000, 1, o(1, 3, 0, 0, 0, 0, 16'd2));
    add(0, 1, 4'b0000, 1, o(0, 3, 0, 1, 0, 0, 16'd3));
    for (int i = 0; i < 7; i++) add(0, 0, 4'b0000, 1, o(0, 3, 0, 1, 0, 0, 16'd3));
    add(0, 0, 4'b0000, 1, o(0, 3, 0, 0, 0, 0, 16'd3));

    Reset = 1'b0; ballot_pulse = 1'b0; close_poll = 1'b0; cand_pulse = 4'b0;
    vote.vote_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("reset_state", {9'd0, obs}, 32'd0);
    @(posedge clock);
    #1;
    Reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ballot, vecs[i].close, vecs[i].cand, vecs[i].ready);
      chk($sformatf("vec%0d", i), {9'd0, obs}, {9'd0, vecs[i].exp});
    end

    // Scenario 3: no press -> expiry 20 cycles after arming.
    step(1, 0, 4'b0, 1);
    first = 0; pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      step(0, 0, 4'b0, 1);
      if (timeout_flag) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    chk("timeout_latency", first, 20);
    chk("timeout_pulses", pulses, 1);
    chk("timeout_idle", {ready_led, vote.vote_valid}, 2'b00);
    chk("timeout_votes", votes_cast, 16'd3);

    // Press on the terminal timer cycle beats the timeout.
    step(1, 0, 4'b0, 1);
    idle_steps(19);
    chk("terminal_armed", {ready_led, timeout_flag}, 2'b10);
    step(0, 0, 4'b0010, 1);
    chk("terminal_commit", {vote.vote_valid, vote.vote_idx, timeout_flag}, {1'b1, 2'd1, 1'b0});
    step(0, 0, 4'b0, 1);
    chk("terminal_count", votes_cast, 16'd4);
    idle_steps(8);
    chk("terminal_beep_done", {beep, ready_led}, 2'b00);

    // Scenario 4: tally stalls for 5 cycles.
    step(1, 0, 4'b0, 1);
    step(0, 0, 4'b0100, 0);
    for (int i = 0; i < 5; i++) begin
      step(i == 2, 0, 4'b0001, 0);
      chk($sformatf("stall%0d", i), {vote.vote_valid, vote.vote_idx, votes_cast},
          {1'b1, 2'd2, 16'd4});
    end
    step(0, 0, 4'b0, 1);
    chk("stall_accept", {vote.vote_valid, beep, votes_cast}, {1'b0, 1'b1, 16'd5});
    idle_steps(8);

    // Scenario 6: reset in COMMIT drops the vote at once.
    step(1, 0, 4'b0, 1);
    step(0, 0, 4'b1000, 0);
    chk("pre_reset_valid", vote.vote_valid, 1'b1);
    #2 Reset = 1'b0;
    #1;
    chk("async_reset", {vote.vote_valid, votes_cast, beep, ready_led}, {1'b0, 16'd0, 2'b00});
    @(posedge clock);
    #1 Reset = 1'b1;

    // Saturation at 16'hFFFF.
    force dut.vote_cnt = 16'hFFFF;
    step(0, 0, 4'b0, 1);
    release dut.vote_cnt;
    step(0, 0, 4'b0, 1);
    chk("preload", votes_cast, 16'hFFFF);
    step(1, 0, 4'b0, 1);
    step(0, 0, 4'b0001, 1);
    step(0, 0, 4'b0, 1);
    chk("saturate", {beep, votes_cast}, {1'b1, 16'hFFFF});
    idle_steps(8);

    // Scenario 5: close beats ballot; CLOSED ignores everything.
    step(1, 1, 4'b0, 1);
    chk("close_priority", {poll_closed, ready_led}, 2'b10);
    step(1, 0, 4'b0, 1);
    step(0, 0, 4'b0001, 1);
    step(0, 0, 4'b0, 1);
    chk("closed_frozen", {9'd0, obs}, {9'd0, o(0, 0, 0, 0, 0, 1, 16'hFFFF)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
